// File: rtl/mailbox_fifo_channel.sv
// Mailbox channel with a DEPTH-entry message FIFO behind the CTRL/DATA/STATUS registers,
// a fill-level interrupt, sticky overflow/underflow flags and a CTRL-triggered flush.
module mailbox_fifo_channel #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    wen,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    ren,
  output logic [DW-1:0] rdata,
  input  logic          clear_intr,
  output logic          int_flag,
  output logic [31:0]   ch_ctrl,
  output logic [31:0]   ch_status
);

  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          int_en, underflow, overflow, int_pending;
  logic [1:0]    mode;
  logic [13:0]   threshold, thr;
  logic          empty, full, pop_req, flush, do_pop, do_push, set_evt;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_req = (ren == 3'b010);
  assign flush   = wen[0] & wdata[14];
  // A pop on a full FIFO frees the slot, so a same-cycle push is still accepted.
  assign do_pop  = pop_req & ~empty;
  assign do_push = wen[1] & (~full | do_pop);

  assign count_nxt = flush ? '0 : count + CW'(do_push) - CW'(do_pop);
  assign thr       = (threshold == '0) ? 14'd1 : threshold;
  // Edge-triggered on count movement only; a threshold rewrite alone never fires.
  assign set_evt   = (14'(count) < thr) && (14'(count_nxt) >= thr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      int_en      <= 1'b0;
      mode        <= '0;
      threshold   <= '0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (wen[0]) begin
        int_en    <= wdata[31];
        mode      <= wdata[30:29];
        threshold <= wdata[28:15];
      end
      if (pop_req && empty)               underflow <= 1'b1;
      else if (wen[2] && wdata[4])        underflow <= 1'b0;
      if (wen[1] && full && !do_pop)      overflow  <= 1'b1;
      else if (wen[2] && wdata[3])        overflow  <= 1'b0;
      if (set_evt)                                    int_pending <= 1'b1;
      else if (clear_intr || (wen[2] && wdata[1]))    int_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign ch_ctrl   = {int_en, mode, threshold, 15'b0};
  assign ch_status = {8'(count), 19'b0, underflow, overflow, full, int_pending, ~empty};
  assign int_flag  = int_en & int_pending;

  always_comb begin
    rdata = '0;
    case (ren)
      3'b001:  rdata = DW'(ch_ctrl);
      3'b010:  if (!empty) rdata = mem[rd_ptr];
      3'b100:  rdata = DW'(ch_status);
      default: rdata = '0;
    endcase
  end

endmodule
